// File: rtl/protocol_stream.sv
// protocol_stream: oversampled serial command decoder feeding the LED frame buffer.
// Frame layout, MSB first: CMD (c_cmd_w) | LEN (c_len_w, bytes) | PAYLOAD (LEN*8 bits).
// Commands: 0 keyframe (type, duration, words from 0), 1 write-at (16b addr, words), 2 sync.
// Build option PROTOCOL_STREAM_CRC_EN: the last payload byte is a CRC-8 (poly 0x07, init 0)
// over command, length and preceding payload; it is checked at frame end, never decoded.

module protocol_stream #(
  parameter int unsigned c_ledboards    = 30,
  parameter int unsigned c_ch_per_board = 32,
  parameter int unsigned c_channels     = c_ledboards * c_ch_per_board,
  parameter int unsigned c_addr_w       = $clog2(c_channels),
  parameter int unsigned c_bpc          = 12,
  parameter int unsigned c_cmd_w        = 5,
  parameter int unsigned c_len_w        = 11,
  parameter int unsigned c_type_w       = 6,
  parameter int unsigned c_time_w       = 10,
  parameter int unsigned c_sync_stages  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_dck,
  input  logic                i_cs,
  input  logic                i_mosi,
  output logic                o_wen,
  output logic [c_addr_w-1:0] o_addr,
  output logic [c_bpc-1:0]    o_data,
  output logic [c_type_w-1:0] o_type,
  output logic [c_time_w-1:0] o_time,
  output logic                o_sync,
  output logic                o_frame_ok,
  output logic                o_err,
  output logic                o_crc_err
);

  localparam int unsigned c_cnt_w  = c_len_w + 3;
  localparam int unsigned c_kf_hdr = c_type_w + c_time_w;
  localparam int unsigned c_wa_hdr = 16;
  localparam int unsigned c_fld_w  = (c_kf_hdr > c_wa_hdr) ? c_kf_hdr : c_wa_hdr;
  localparam int unsigned c_wa_w   = c_addr_w + 1;  // one spare bit to represent "past the end"
  localparam int unsigned c_wcnt_w = $clog2(c_bpc);

  localparam logic [c_cmd_w-1:0]  c_cmd_kf    = c_cmd_w'(0);
  localparam logic [c_cmd_w-1:0]  c_cmd_wa    = c_cmd_w'(1);
  localparam logic [c_cmd_w-1:0]  c_cmd_sync  = c_cmd_w'(2);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cmd_last  = c_cnt_w'(c_cmd_w - 1);
  localparam logic [c_cnt_w-1:0]  c_len_last  = c_cnt_w'(c_len_w - 1);
  localparam logic [c_cnt_w-1:0]  c_kf_last   = c_cnt_w'(c_kf_hdr - 1);
  localparam logic [c_cnt_w-1:0]  c_wa_last   = c_cnt_w'(c_wa_hdr - 1);
  localparam logic [c_wcnt_w-1:0] c_word_last = c_wcnt_w'(c_bpc - 1);
  localparam logic [c_wa_w-1:0]   c_chan_lim  = c_wa_w'(c_channels);
  localparam logic [16:0]         c_start_lim = 17'(c_channels);

  typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StEnd} state_e;

  // Input synchronisers
  logic [c_sync_stages-1:0] dck_sync_q, cs_sync_q, mosi_sync_q;
  logic dck_prev_q, dck_s, cs_s, mosi_s, bit_acc;

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_cmd_w-1:0]  cmd_q, cmd_d, cmd_n;
  logic [c_len_w-1:0]  len_q, len_d, len_n;
  logic [c_fld_w-2:0]  fld_q, fld_d;
  logic [c_fld_w-1:0]  fld_n;
  logic [c_bpc-2:0]    word_q, word_d;
  logic [c_bpc-1:0]    word_n;
  logic [c_wcnt_w-1:0] wcnt_q, wcnt_d;
  logic [c_wa_w-1:0]   waddr_q, waddr_d;
  logic                fault_q, fault_d;     // sticky payload error
  logic                blk_q, blk_d;         // bad start address: no writes this frame
  logic                hdr_done_q, hdr_done_d;
  logic                wen_q, wen_d, sync_q, sync_d, ok_q, ok_d, errp_q, errp_d;
  logic [c_addr_w-1:0] addr_q, addr_d;
  logic [c_bpc-1:0]    data_q, data_d;
  logic [c_type_w-1:0] type_q, type_d;
  logic [c_time_w-1:0] time_q, time_d;
  logic [c_cnt_w-1:0]  len_bits, data_bits;
  logic                hdr_short, cmd_unknown, frame_bad;

`ifdef PROTOCOL_STREAM_CRC_EN
  logic [7:0] crc_q, crc_d, rx_crc_q, rx_crc_d;
  logic       crc_err_q, crc_err_d, crc_bad;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  assign dck_s   = dck_sync_q[c_sync_stages-1];
  assign cs_s    = cs_sync_q[c_sync_stages-1];
  assign mosi_s  = mosi_sync_q[c_sync_stages-1];
  assign bit_acc = dck_s & ~dck_prev_q & ~cs_s;

  assign cmd_n  = {cmd_q[c_cmd_w-2:0], mosi_s};
  assign len_n  = {len_q[c_len_w-2:0], mosi_s};
  assign fld_n  = {fld_q, mosi_s};
  assign word_n = {word_q, mosi_s};

  assign len_bits = {len_q, 3'b000};
`ifdef PROTOCOL_STREAM_CRC_EN
  assign data_bits = len_bits - c_cnt_w'(8);
  assign crc_bad   = (rx_crc_q != crc_q);
`else
  assign data_bits = len_bits;
`endif

  assign hdr_short   = ((cmd_q == c_cmd_kf) || (cmd_q == c_cmd_wa)) && !hdr_done_q;
  assign cmd_unknown = (cmd_q > c_cmd_sync);
`ifdef PROTOCOL_STREAM_CRC_EN
  assign frame_bad   = fault_q | hdr_short | cmd_unknown | (len_q == '0);
`else
  assign frame_bad   = fault_q | hdr_short | cmd_unknown;
`endif

  // Synchroniser chains and dck edge history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      dck_prev_q  <= 1'b0;
    end else begin
      dck_sync_q  <= {dck_sync_q[c_sync_stages-2:0], i_dck};
      cs_sync_q   <= {cs_sync_q[c_sync_stages-2:0], i_cs};
      mosi_sync_q <= {mosi_sync_q[c_sync_stages-2:0], i_mosi};
      dck_prev_q  <= dck_s;
    end
  end

  // Next-state, field decode, word assembly and frame-end status
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    fld_d      = fld_q;
    word_d     = word_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    fault_d    = fault_q;
    blk_d      = blk_q;
    hdr_done_d = hdr_done_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    type_d     = type_q;
    time_d     = time_q;
    sync_d     = 1'b0;
    ok_d       = 1'b0;
    errp_d     = 1'b0;
`ifdef PROTOCOL_STREAM_CRC_EN
    crc_d      = crc_q;
    rx_crc_d   = rx_crc_q;
    crc_err_d  = 1'b0;
`endif
    if (cs_s) begin
      // Deselect aborts silently; header outputs and o_addr hold.
      state_d    = StIdle;
      cnt_d      = '0;
      wcnt_d     = '0;
      fault_d    = 1'b0;
      blk_d      = 1'b0;
      hdr_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bit_acc) begin
            cmd_d      = cmd_n;
            cnt_d      = c_cnt_one;
            state_d    = StCmd;
            fault_d    = 1'b0;
            blk_d      = 1'b0;
            hdr_done_d = 1'b0;
            wcnt_d     = '0;
            waddr_d    = '0;
`ifdef PROTOCOL_STREAM_CRC_EN
            crc_d      = crc_step(8'h00, mosi_s);
`endif
          end
        end
        StCmd: begin
          if (bit_acc) begin
            cmd_d = cmd_n;
`ifdef PROTOCOL_STREAM_CRC_EN
            crc_d = crc_step(crc_q, mosi_s);
`endif
            if (cnt_q == c_cmd_last) begin
              cnt_d   = '0;
              state_d = StLen;
            end else begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end
        end
        StLen: begin
          if (bit_acc) begin
            len_d = len_n;
`ifdef PROTOCOL_STREAM_CRC_EN
            crc_d = crc_step(crc_q, mosi_s);
`endif
            if (cnt_q == c_len_last) begin
              cnt_d   = '0;
              state_d = (len_n == '0) ? StEnd : StPayload;
            end else begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end
        end
        StPayload: begin
          if (bit_acc) begin
            cnt_d = cnt_q + c_cnt_one;
            if (cnt_q < data_bits) begin
`ifdef PROTOCOL_STREAM_CRC_EN
              crc_d = crc_step(crc_q, mosi_s);
`endif
              if ((cmd_q == c_cmd_kf) || (cmd_q == c_cmd_wa)) begin
                if (!hdr_done_q) begin
                  fld_d = fld_n[c_fld_w-2:0];
                  if ((cmd_q == c_cmd_kf) && (cnt_q == c_kf_last)) begin
                    hdr_done_d = 1'b1;
                    type_d     = fld_n[c_kf_hdr-1 -: c_type_w];
                    time_d     = fld_n[c_time_w-1:0];
                    waddr_d    = '0;
                  end
                  if ((cmd_q == c_cmd_wa) && (cnt_q == c_wa_last)) begin
                    hdr_done_d = 1'b1;
                    if ({1'b0, fld_n[15:0]} >= c_start_lim) begin
                      blk_d   = 1'b1;
                      fault_d = 1'b1;
                    end else begin
                      waddr_d = {1'b0, fld_n[c_addr_w-1:0]};
                    end
                  end
                end else begin
                  word_d = word_n[c_bpc-2:0];
                  if (wcnt_q == c_word_last) begin
                    wcnt_d = '0;
                    if (!blk_q) begin
                      if (waddr_q < c_chan_lim) begin
                        wen_d   = 1'b1;
                        addr_d  = waddr_q[c_addr_w-1:0];
                        data_d  = word_n;
                        waddr_d = waddr_q + c_wa_w'(1);
                      end else begin
                        fault_d = 1'b1;  // address parks at the end, no wrap
                      end
                    end
                  end else begin
                    wcnt_d = wcnt_q + c_wcnt_w'(1);
                  end
                end
              end
            end else begin
`ifdef PROTOCOL_STREAM_CRC_EN
              rx_crc_d = {rx_crc_q[6:0], mosi_s};
`endif
            end
            if ((cnt_q + c_cnt_one) == len_bits) begin
              state_d = StEnd;
            end
          end
        end
        StEnd: begin
          state_d = StIdle;
          cnt_d   = '0;
          errp_d  = frame_bad;
`ifdef PROTOCOL_STREAM_CRC_EN
          crc_err_d = !frame_bad && crc_bad;
          ok_d      = !frame_bad && !crc_bad;
`else
          ok_d      = !frame_bad;
`endif
          sync_d = ok_d && (cmd_q == c_cmd_sync);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      fld_q      <= '0;
      word_q     <= '0;
      wcnt_q     <= '0;
      waddr_q    <= '0;
      fault_q    <= 1'b0;
      blk_q      <= 1'b0;
      hdr_done_q <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= '0;
      time_q     <= '0;
      sync_q     <= 1'b0;
      ok_q       <= 1'b0;
      errp_q     <= 1'b0;
`ifdef PROTOCOL_STREAM_CRC_EN
      crc_q      <= '0;
      rx_crc_q   <= '0;
      crc_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      fld_q      <= fld_d;
      word_q     <= word_d;
      wcnt_q     <= wcnt_d;
      waddr_q    <= waddr_d;
      fault_q    <= fault_d;
      blk_q      <= blk_d;
      hdr_done_q <= hdr_done_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      type_q     <= type_d;
      time_q     <= time_d;
      sync_q     <= sync_d;
      ok_q       <= ok_d;
      errp_q     <= errp_d;
`ifdef PROTOCOL_STREAM_CRC_EN
      crc_q      <= crc_d;
      rx_crc_q   <= rx_crc_d;
      crc_err_q  <= crc_err_d;
`endif
    end
  end

  assign o_wen      = wen_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_type     = type_q;
  assign o_time     = time_q;
  assign o_sync     = sync_q;
  assign o_frame_ok = ok_q;
  assign o_err      = errp_q;
`ifdef PROTOCOL_STREAM_CRC_EN
  assign o_crc_err  = crc_err_q;
`else
  assign o_crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_protocol_stream.sv
// Scoreboard bench for protocol_stream: each directed frame queues its expected write strobes
// and status pulse; an independent monitor pops and compares on every DUT pulse.
`timescale 1ns/1ps
module tb_protocol_stream;
`ifdef PROTOCOL_STREAM_CRC_EN
  localparam int c_crc_bytes = 1;
`else
  localparam int c_crc_bytes = 0;
`endif
  // status encoding {sync, frame_ok, err, crc_err}
  localparam logic [3:0] st_ok      = 4'b0100;
  localparam logic [3:0] st_err     = 4'b0010;
  localparam logic [3:0] st_sync_ok = 4'b1100;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_dck = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_mosi = 1'b0;
  logic        o_wen;
  logic [9:0]  o_addr;
  logic [11:0] o_data;
  logic [5:0]  o_type;
  logic [9:0]  o_time;
  logic        o_sync, o_frame_ok, o_err, o_crc_err;

  typedef struct packed {
    logic        wen;
    logic [3:0]  st;
    logic [9:0]  addr;
    logic [11:0] data;
  } ev_t;

  ev_t  exp_q[$];
  logic bits_q[$];
  int   checks = 0;
  int   errors = 0;

  protocol_stream dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_dck      (i_dck),
    .i_cs       (i_cs),
    .i_mosi     (i_mosi),
    .o_wen      (o_wen),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .o_type     (o_type),
    .o_time     (o_time),
    .o_sync     (o_sync),
    .o_frame_ok (o_frame_ok),
    .o_err      (o_err),
    .o_crc_err  (o_crc_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, expv);
    end
  endtask

  task automatic exp_wen(input int a, input int d);
    ev_t e;
    e = '0;
    e.wen = 1'b1;
    e.addr = 10'(a);
    e.data = 12'(d);
    exp_q.push_back(e);
  endtask

  task automatic exp_st(input logic [3:0] st);
    ev_t e;
    e = '0;
    e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic push_field(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic hdr(input int cmd, input int len);
    bits_q.delete();
    push_field(cmd, 5);
    push_field(len, 11);
  endtask

  task automatic kf_frame(input int ty, input int tm, input int w0, input int w1);
    hdr(0, 5 + c_crc_bytes);
    push_field(ty, 6);
    push_field(tm, 10);
    push_field(w0, 12);
    push_field(w1, 12);
  endtask

`ifdef PROTOCOL_STREAM_CRC_EN
  function automatic logic [7:0] crc8_of_queue();
    logic [7:0] c;
    c = 8'h00;
    foreach (bits_q[i]) c = {c[6:0], 1'b0} ^ ((c[7] ^ bits_q[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic append_crc(input int flip);
    push_field(int'(crc8_of_queue()) ^ flip, 8);
  endtask
`endif

  task automatic end_frame();
`ifdef PROTOCOL_STREAM_CRC_EN
    append_crc(0);
`endif
  endtask

  // Host side: each dck phase lasts 5 i_clk cycles; cs stays low afterwards.
  task automatic send_bits(input int count);
    @(negedge i_clk);
    i_cs = 1'b0;
    for (int i = 0; i < count; i++) begin
      @(negedge i_clk);
      i_mosi = bits_q[i];
      repeat (4) @(negedge i_clk);
      i_dck = 1'b1;
      repeat (5) @(negedge i_clk);
      i_dck = 1'b0;
    end
    repeat (6) @(negedge i_clk);
  endtask

  task automatic cs_high();
    i_cs = 1'b1;
    repeat (8) @(negedge i_clk);
  endtask

  // Monitor: every strobe or status pulse must match the head of the queue.
  always @(negedge i_clk) begin
    ev_t got;
    ev_t e;
    if (o_wen || o_sync || o_frame_ok || o_err || o_crc_err) begin
      got = '0;
      got.wen = o_wen;
      got.st = {o_sync, o_frame_ok, o_err, o_crc_err};
      if (o_wen) begin
        got.addr = o_addr;
        got.data = o_data;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got wen=%0b st=%b addr=%0d data=%h, required no pulse",
                 got.wen, got.st, got.addr, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard: got wen=%0b st=%b addr=%0d data=%h, required wen=%0b st=%b addr=%0d data=%h",
                   got.wen, got.st, got.addr, got.data, e.wen, e.st, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge i_clk);
    check("rst_wen", int'(o_wen), 0);
    check("rst_addr", int'(o_addr), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_type", int'(o_type), 0);
    check("rst_time", int'(o_time), 0);
    check("rst_status", int'({o_sync, o_frame_ok, o_err, o_crc_err}), 0);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);

    // Keyframe: two words from address 0
    kf_frame(5, 100, 'hABC, 'h123);
    end_frame();
    exp_wen(0, 'hABC);
    exp_wen(1, 'h123);
    exp_st(st_ok);
    send_bits(bits_q.size());
    cs_high();
    check("kf_type", int'(o_type), 5);
    check("kf_time", int'(o_time), 100);

    // WRITE_AT 958: fills the last two channels
    hdr(1, 5 + c_crc_bytes);
    push_field(958, 16);
    push_field('h001, 12);
    push_field('hFFF, 12);
    end_frame();
    exp_wen(958, 'h001);
    exp_wen(959, 'hFFF);
    exp_st(st_ok);
    send_bits(bits_q.size());
    cs_high();

    // WRITE_AT 959: second word runs off the end
    hdr(1, 5 + c_crc_bytes);
    push_field(959, 16);
    push_field('h5A5, 12);
    push_field('h0F0, 12);
    end_frame();
    exp_wen(959, 'h5A5);
    exp_st(st_err);
    send_bits(bits_q.size());
    cs_high();
    check("boundary_addr_hold", int'(o_addr), 959);

    // Abort after 6 bits of the second word
    kf_frame(3, 7, 'h456, 'h789);
    exp_wen(0, 'h456);
    send_bits(16 + 16 + 12 + 6);
    cs_high();
    check("abort_type", int'(o_type), 3);
    check("abort_time", int'(o_time), 7);

    // Full keyframe after abort
    kf_frame(9, 513, 'hDEF, 'h321);
    end_frame();
    exp_wen(0, 'hDEF);
    exp_wen(1, 'h321);
    exp_st(st_ok);
    send_bits(bits_q.size());
    cs_high();
    check("kf2_type", int'(o_type), 9);
    check("kf2_time", int'(o_time), 513);

    // Header overrun: keyframe with one data byte
    hdr(0, 1 + c_crc_bytes);
    push_field(2, 6);
    push_field(3, 2);
    end_frame();
    exp_st(st_err);
    send_bits(bits_q.size());
    cs_high();
    check("overrun_type_hold", int'(o_type), 9);
    check("overrun_time_hold", int'(o_time), 513);

    // Unknown command, then SYNC back-to-back with cs held low
    hdr(7, 2 + c_crc_bytes);
    push_field('hBEEF, 16);
    end_frame();
    exp_st(st_err);
    send_bits(bits_q.size());
    hdr(2, 0 + c_crc_bytes);
    end_frame();
    exp_st(st_sync_ok);
    send_bits(bits_q.size());
    cs_high();

`ifdef PROTOCOL_STREAM_CRC_EN
    kf_frame(5, 100, 'hABC, 'h123);
    append_crc(0);
    exp_wen(0, 'hABC);
    exp_wen(1, 'h123);
    exp_st(st_ok);
    send_bits(bits_q.size());
    cs_high();
    kf_frame(5, 100, 'hABC, 'h123);
    append_crc(1);
    exp_wen(0, 'hABC);
    exp_wen(1, 'h123);
    exp_st(4'b0001);
    send_bits(bits_q.size());
    cs_high();
    hdr(2, 0);
    exp_st(st_err);
    send_bits(bits_q.size());
    cs_high();
`endif

    // Reset mid-frame after the keyframe header: outputs clear, no pulses
    kf_frame(33, 44, 'h111, 'h222);
    send_bits(20);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("midrst_type", int'(o_type), 0);
    check("midrst_time", int'(o_time), 0);
    i_cs = 1'b1;
    i_dck = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (8) @(negedge i_clk);

    // Recovery frame
    hdr(2, 0 + c_crc_bytes);
    end_frame();
    exp_st(st_sync_ok);
    send_bits(bits_q.size());
    cs_high();

    repeat (20) @(negedge i_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
